// File: rtl/evt_pkg.sv
// Shared types and constants for the event pulse generator.
// Provides the FSM state enum and the default field width.
package evt_pkg;

  localparam int EVT_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } evt_state_e;

endpackage

// File: rtl/evt_phase_counter.sv
// Modulo-P phase counter with clear, enable and registered wrap strobe.
// Ports: clk_in, rst_n_in, clr, en, period (P>=1), last (phase==P-1), wrap.
module evt_phase_counter
  import evt_pkg::*;
#(
  parameter int WIDTH = EVT_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] period,
  output logic             last,
  output logic             wrap
);

  logic [WIDTH-1:0] phase;

  assign last = (phase == period - WIDTH'(1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      phase <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= en & last & ~clr;
      if (clr) begin
        phase <= '0;
      end else if (en) begin
        phase <= last ? '0 : phase + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/evt_pulse_gen.sv
// Programmable event-strobe generator: pulses every P cycles, N times or forever.
// Ports: clk_in, rst_n_in, start_in, stop_in, period_in, pulse_count_in,
//   evt_out, busy_out, done_out, pulses_sent_out.
// Option: define EVT_PULSE_GEN_LIVE_PERIOD_EN to resample period_in on each pulse.
module evt_pulse_gen
  import evt_pkg::*;
#(
  parameter int WIDTH = EVT_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic             stop_in,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] pulse_count_in,
  output logic             evt_out,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] pulses_sent_out
);

  evt_state_e       state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] sent_q, sent_d;
  logic [WIDTH-1:0] sent_inc;
  logic             done_q, done_d;
  logic             load;
  logic             run_en;
  logic             last;
  logic             wrap;

  function automatic logic [WIDTH-1:0] eff_period(
    input logic [WIDTH-1:0] p
  );
    return (p == '0) ? WIDTH'(1) : p;
  endfunction

  assign sent_inc = sent_q + WIDTH'(1);

  evt_phase_counter #(
    .WIDTH(WIDTH)
  ) u_phase (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .clr     (load),
    .en      (run_en),
    .period  (period_q),
    .last    (last),
    .wrap    (wrap)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      period_q <= WIDTH'(1);
      count_q  <= '0;
      sent_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      count_q  <= count_d;
      sent_q   <= sent_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    count_d  = count_q;
    sent_d   = sent_q;
    done_d   = 1'b0;
    load     = 1'b0;
    run_en   = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        // stop dominates a simultaneous start
        if (start_in && !stop_in) begin
          state_d  = RUN;
          load     = 1'b1;
          period_d = eff_period(period_in);
          count_d  = pulse_count_in;
          sent_d   = '0;
        end
      end
      (state_q == RUN): begin
        if (stop_in) begin
          state_d = IDLE;
        end else begin
          run_en = 1'b1;
          if (last) begin
            sent_d = sent_inc;
`ifdef EVT_PULSE_GEN_LIVE_PERIOD_EN
            period_d = eff_period(period_in);
`else
            period_d = period_q;
`endif
            if (count_q != '0 && sent_inc == count_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign evt_out         = wrap;
  assign busy_out        = (state_q == RUN);
  assign done_out        = done_q;
  assign pulses_sent_out = sent_q;

endmodule
